// File: rtl/buff_pkg.sv
// Definitions shared by the CPU-side byte buffers (buffin/buffout):
// FSM state encodings, default address width and byte-phase constants.
package buff_pkg;

    localparam int ADDR_W_DEF = 6;

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic BYTE_HI = 1'b0;
    localparam logic BYTE_LO = 1'b1;

    // Pick the byte of a 16-bit word addressed by the current byte phase.
    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic ph);
        return (ph == BYTE_LO) ? word[7:0] : word[15:8];
    endfunction

endpackage

// File: rtl/buffout_mem.sv
// Word store for buffout: synchronous write port, asynchronous read port.
// Contents are deliberately left unreset.
module buffout_mem #(
    parameter int ADDR_W = 6,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DW-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/buffout.sv
// Output-side result buffer: 16-bit CPU words in, bytes out (hi first),
// with end-of-program tracking so the consumer can tell when it has drained all results.
module buffout
    import buff_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DW     = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [DW-1:0]   wdata,
    input  logic            wre,
    input  logic            endf,
    input  logic            rd,
    output logic [7:0]      q,
    output logic            valid,
    output logic            full,
    output logic [ADDR_W:0] count,
    output logic            phase,
    output logic            done,
    output logic            ovf
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              phase_q, phase_d;
    logic [1:0]        state_q, state_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              full_w, valid_w;
    logic              wr_acc, rd_act, word_done, last_out;
    logic [DW-1:0]     head_word;

    assign full_w  = (count_q == DEPTH_C);
    assign valid_w = (count_q != '0);

    // Fullness is judged on the registered count, so a slot freed this cycle
    // cannot absorb a same-cycle write.
    assign wr_acc    = wre && !full_w;
    assign rd_act    = rd && valid_w;
    assign word_done = rd_act && (phase_q == BYTE_LO);
    assign last_out  = word_done && !wr_acc && (count_q == ONE_C);

    buffout_mem #(
        .ADDR_W (ADDR_W),
        .DW     (DW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .waddr  (wp_q),
        .wdata  (wdata),
        .raddr  (rp_q),
        .rdata  (head_word)
    );

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        phase_d = phase_q;
        ovf_d   = ovf_q || (wre && full_w);

        if (wr_acc) begin
            wp_d = wp_q + ADDR_W'(1);
        end

        if (rd_act) begin
            if (phase_q == BYTE_HI) begin
                phase_d = BYTE_LO;
            end else begin
                phase_d = BYTE_HI;
                rp_d    = rp_q + ADDR_W'(1);
            end
        end

        case ({wr_acc, word_done})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (wr_acc) begin
                    state_d = endf ? DRAIN : ACTIVE;
                end else if (endf) begin
                    state_d = DONE;
                end
            end
            ACTIVE: begin
                if (last_out) begin
                    state_d = endf ? DONE : EMPTY;
                end else if (endf) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_out) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // endf held high is ignored here; only a new result restarts the run.
                if (wr_acc) begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = EMPTY;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            phase_q <= BYTE_HI;
            state_q <= EMPTY;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            phase_q <= phase_d;
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q     = sel_byte(head_word, phase_q);
    assign valid = valid_w;
    assign full  = full_w;
    assign count = count_q;
    assign phase = phase_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule
